// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master dmem arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to
// whichever master was not served last.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic   valid0,
  input  logic   valid1,
  input  owner_e last,
  output logic   any_valid,
  output owner_e winner
);

  always_comb begin
    any_valid = valid0 | valid1;
    winner    = M0;
    if (valid0 && valid1) begin
      winner = (last == M0) ? M1 : M0;
    end else if (valid1) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port dmem between the core (m0) and the fill engine (m1).
// Define ARB_TIMEOUT_EN to add a BUSY watchdog that force-completes with TIMEOUT_RDATA and a sticky timeout_err.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_q, last_d;
  owner_e      winner;
  logic        any_valid;
  logic        s_valid_q, s_valid_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic        complete;
  logic        timed_out;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
    $error("dmem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  rr_pick2 u_pick (
    .valid0    (m0_valid),
    .valid1    (m1_valid),
    .last      (last_q),
    .any_valid (any_valid),
    .winner    (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= M0;
      last_q    <= M1;
      s_valid_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      s_valid_q <= s_valid_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
    end
  end

  // Request fields are captured only at grant, so a master that misbehaves
  // while BUSY cannot disturb what the slave sees.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    s_valid_d = s_valid_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d   = winner;
          s_valid_d = 1'b1;
          state_d   = BUSY;
          if (winner == M1) begin
            s_addr_d  = m1_addr;
            s_wdata_d = m1_wdata;
            s_wstrb_d = m1_wstrb;
          end else begin
            s_addr_d  = m0_addr;
            s_wdata_d = m0_wdata;
            s_wstrb_d = m0_wstrb;
          end
        end
      end
      BUSY: begin
        if (complete) begin
          last_d    = owner_q;
          s_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    complete = (state_q == BUSY) && (s_ready || timed_out);
    m0_ready = complete && (owner_q == M0);
    m1_ready = complete && (owner_q == M1);
    m0_rdata = timed_out ? TIMEOUT_RDATA : s_rdata;
    m1_rdata = timed_out ? TIMEOUT_RDATA : s_rdata;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout_err_q, timeout_err_d;

  // A same-cycle s_ready beats expiry, so timed_out is masked by it.
  assign timed_out = (state_q == BUSY) && !s_ready &&
                     (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timeout_err_d = timeout_err_q | timed_out;
    timer_d       = '0;
    if (state_q == BUSY) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign s_valid = s_valid_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wstrb = s_wstrb_q;

endmodule
